// File: rtl/inst_fetch_queue_pkg.sv
// Shared fetch/decode definitions: bus widths, NOP encoding, queue depth and entry layout.
package inst_fetch_queue_pkg;

  localparam int unsigned InstAddrBus = 32;
  localparam int unsigned InstBus     = 32;
  localparam int unsigned FQ_DEPTH    = 8;

  // andi r0, r0, 0
  localparam logic [InstBus-1:0] INST_NOP = 32'h0340_0000;

  typedef logic [InstAddrBus-1:0] inst_addr_t;
  typedef logic [InstBus-1:0]     inst_t;

  typedef struct packed {
    inst_addr_t pc;
    inst_t      inst;
  } fq_entry_t;

endpackage

// File: rtl/inst_fetch_queue_fq_ptr_ctrl.sv
// Pointer/occupancy control for the fetch queue: head, tail, count, leading-ones enqueue
// count, clamped dequeue count and flush. Optional same-cycle bypass under QUEUE_BYPASS_EN.
module fq_ptr_ctrl #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned DEPTH       = 8,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1),
  localparam int unsigned PTR_W      = $clog2(DEPTH),
  localparam int unsigned ACC_W      = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush_i,
  input  logic [FETCH_WIDTH-1:0] if_valid_i,
  input  logic [ACC_W-1:0]       id_accept_i,
  output logic                   if_ready_o,
  output logic [CNT_W-1:0]       n_enq_o,
  output logic [CNT_W-1:0]       n_skip_o,
  output logic [PTR_W-1:0]       head_o,
  output logic [PTR_W-1:0]       tail_o,
  output logic [CNT_W-1:0]       count_o
);

  localparam logic [CNT_W-1:0] ReadyMax = CNT_W'(DEPTH - FETCH_WIDTH);
  localparam logic [CNT_W-1:0] IssueMax = CNT_W'(ISSUE_WIDTH);

  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] n_lead, n_deq, avail;
  logic             run, byp;

  // Conservative: only registered count, a same-cycle dequeue does not help.
  assign if_ready_o = (count_q <= ReadyMax);
  assign n_enq_o    = (if_ready_o && !flush_i) ? n_lead : '0;
  assign n_skip_o   = byp ? n_deq : '0;
  assign head_o     = head_q;
  assign tail_o     = tail_q;
  assign count_o    = count_q;

`ifdef QUEUE_BYPASS_EN
  assign byp = (count_q == '0) && !flush_i;
`else
  assign byp = 1'b0;
`endif

  // Leading-ones count of lane valids; lanes after the first gap are ignored
  always_comb begin
    n_lead = '0;
    run    = 1'b1;
    for (int unsigned k = 0; k < FETCH_WIDTH; k++) begin
      run = run & if_valid_i[k];
      if (run) n_lead = n_lead + CNT_W'(1);
    end
  end

  // Dequeue count clamped to what is presented and to the issue width
  always_comb begin
    avail = byp ? n_enq_o : count_q;
    n_deq = CNT_W'(id_accept_i);
    if (avail < n_deq) n_deq = avail;
    if (IssueMax < n_deq) n_deq = IssueMax;
  end

  // Next pointers; bypassed-and-consumed lanes never touch storage
  always_comb begin
    head_d  = head_q + PTR_W'(n_deq - n_skip_o);
    tail_d  = tail_q + PTR_W'(n_enq_o - n_skip_o);
    count_d = count_q + n_enq_o - n_deq;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end
  end

  // Pointer and count state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/inst_fetch_queue.sv
// Multi-lane in-order instruction queue between fetch and decode. Holds the storage array
// and output muxing; pointer control lives in fq_ptr_ctrl.
// Optional macro QUEUE_BYPASS_EN: empty-queue enqueues are presented to decode same cycle.
module inst_fetch_queue
  import inst_fetch_queue_pkg::*;
#(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned ISSUE_WIDTH = 2,
  parameter int unsigned DEPTH       = FQ_DEPTH,
  localparam int unsigned CNT_W      = $clog2(DEPTH + 1),
  localparam int unsigned ACC_W      = $clog2(ISSUE_WIDTH + 1)
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               flush_i,
  input  logic [FETCH_WIDTH-1:0]             if_valid_i,
  input  logic [InstAddrBus*FETCH_WIDTH-1:0] if_pc_i,
  input  logic [InstBus*FETCH_WIDTH-1:0]     if_inst_i,
  output logic                               if_ready_o,
  output logic [ISSUE_WIDTH-1:0]             id_valid_o,
  output logic [InstAddrBus*ISSUE_WIDTH-1:0] id_pc_o,
  output logic [InstBus*ISSUE_WIDTH-1:0]     id_inst_o,
  input  logic [ACC_W-1:0]                   id_accept_i,
  output logic [CNT_W-1:0]                   occupancy_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [PTR_W-1:0]       head, tail, rd_addr;
  logic [CNT_W-1:0]       count, n_enq, n_skip;
  logic [FETCH_WIDTH-1:0] wr_en;
  logic [PTR_W-1:0]       wr_addr [FETCH_WIDTH];
  fq_entry_t              mem_q   [DEPTH];

  fq_ptr_ctrl #(
    .FETCH_WIDTH(FETCH_WIDTH),
    .ISSUE_WIDTH(ISSUE_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ptr_ctrl (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .id_accept_i(id_accept_i),
    .if_ready_o (if_ready_o),
    .n_enq_o    (n_enq),
    .n_skip_o   (n_skip),
    .head_o     (head),
    .tail_o     (tail),
    .count_o    (count)
  );

  assign occupancy_o = count;

  // Lane j lands at tail + (j - skip); lanes consumed through the bypass are skipped
  always_comb begin
    for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
      wr_en[j]   = (CNT_W'(j) >= n_skip) && (CNT_W'(j) < n_enq);
      wr_addr[j] = tail + PTR_W'(CNT_W'(j) - n_skip);
    end
  end

  // Storage array, intentionally not reset
  always_ff @(posedge clk) begin
    for (int unsigned j = 0; j < FETCH_WIDTH; j++) begin
      if (wr_en[j]) begin
        mem_q[wr_addr[j]] <= '{pc:   if_pc_i[InstAddrBus*j +: InstAddrBus],
                               inst: if_inst_i[InstBus*j +: InstBus]};
      end
    end
  end

`ifdef QUEUE_BYPASS_EN
  // Fetch lanes padded so every issue lane index stays in range
  logic [InstAddrBus*(FETCH_WIDTH+ISSUE_WIDTH)-1:0] if_pc_ext;
  logic [InstBus*(FETCH_WIDTH+ISSUE_WIDTH)-1:0]     if_inst_ext;
  logic                                             byp;
  assign byp         = (count == '0) && !flush_i;
  assign if_pc_ext   = {{(InstAddrBus*ISSUE_WIDTH){1'b0}}, if_pc_i};
  assign if_inst_ext = {{(InstBus*ISSUE_WIDTH){1'b0}}, if_inst_i};
`endif

  // Head lanes to decode; invalid lanes drive zero
  always_comb begin
    id_valid_o = '0;
    id_pc_o    = '0;
    id_inst_o  = '0;
    rd_addr    = '0;
    for (int unsigned k = 0; k < ISSUE_WIDTH; k++) begin
      rd_addr = head + PTR_W'(k);
`ifdef QUEUE_BYPASS_EN
      if (byp) begin
        if (CNT_W'(k) < n_enq) begin
          id_valid_o[k]                          = 1'b1;
          id_pc_o[InstAddrBus*k +: InstAddrBus]  = if_pc_ext[InstAddrBus*k +: InstAddrBus];
          id_inst_o[InstBus*k +: InstBus]        = if_inst_ext[InstBus*k +: InstBus];
        end
      end else
`endif
      if (count > CNT_W'(k)) begin
        id_valid_o[k]                         = 1'b1;
        id_pc_o[InstAddrBus*k +: InstAddrBus] = mem_q[rd_addr].pc;
        id_inst_o[InstBus*k +: InstBus]       = mem_q[rd_addr].inst;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Scoreboard bench for inst_fetch_queue (FETCH_WIDTH=2, ISSUE_WIDTH=2, DEPTH=8).
// Stimulus pushes accepted fetch entries; a negedge monitor pops consumed lanes and compares.
module tb_inst_fetch_queue;
  import inst_fetch_queue_pkg::*;

  localparam int FW = 2;
  localparam int IW = 2;
  localparam int D  = 8;
`ifdef QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush_i = 1'b0;
  logic [1:0]  if_valid_i = '0;
  logic [63:0] if_pc_i = '0;
  logic [63:0] if_inst_i = '0;
  logic [1:0]  id_accept_i = '0;
  logic        if_ready_o;
  logic [1:0]  id_valid_o;
  logic [63:0] id_pc_o;
  logic [63:0] id_inst_o;
  logic [3:0]  occupancy_o;

  int checks = 0;
  int failures = 0;
  int m_cnt = 0;
  int m_nxt = 0;
  int m_enq_cur = 0;
  logic [31:0] next_pc;
  logic [31:0] pc0;
  fq_entry_t sb[$];

  inst_fetch_queue #(
    .FETCH_WIDTH(FW),
    .ISSUE_WIDTH(IW),
    .DEPTH      (D)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .flush_i    (flush_i),
    .if_valid_i (if_valid_i),
    .if_pc_i    (if_pc_i),
    .if_inst_i  (if_inst_i),
    .if_ready_o (if_ready_o),
    .id_valid_o (id_valid_o),
    .id_pc_o    (id_pc_o),
    .id_inst_o  (id_inst_o),
    .id_accept_i(id_accept_i),
    .occupancy_o(occupancy_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] pc);
    return {pc[15:0], pc[31:16]} ^ INST_NOP;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Drive one cycle of stimulus and advance the reference count/scoreboard
  task automatic drive(input logic [1:0] v, input int acc, input logic fl);
    int ne, avail, nd;
    if_valid_i  = v;
    id_accept_i = 2'(acc);
    flush_i     = fl;
    if_pc_i     = {next_pc + 32'd4, next_pc};
    if_inst_i   = {inst_of(next_pc + 32'd4), inst_of(next_pc)};
    ne = v[0] ? (v[1] ? 2 : 1) : 0;
    if (m_cnt > D - FW || fl) ne = 0;
    if (fl) begin
      sb.delete();
      m_nxt = 0;
      m_enq_cur = 0;
    end else begin
      for (int j = 0; j < ne; j++) begin
        sb.push_back('{pc: next_pc + 32'(4 * j), inst: inst_of(next_pc + 32'(4 * j))});
      end
      next_pc = next_pc + 32'(4 * ne);
      avail = (BYP && m_cnt == 0) ? ne : m_cnt;
      nd = acc;
      if (avail < nd) nd = avail;
      if (IW < nd) nd = IW;
      m_nxt = m_cnt + ne - nd;
      m_enq_cur = ne;
    end
  endtask

  task automatic commit();
    @(posedge clk);
    #1;
    m_cnt = m_nxt;
    m_enq_cur = 0;
    if_valid_i = '0;
    id_accept_i = '0;
    flush_i = 1'b0;
  endtask

  task automatic step(input logic [1:0] v, input int acc, input logic fl);
    drive(v, acc, fl);
    commit();
  endtask

  // Monitor: checks presented state and pops every lane decode consumes this cycle
  always @(negedge clk) begin : mon
    logic [1:0] ev;
    fq_entry_t  e;
    if (rst) begin
      for (int k = 0; k < IW; k++) begin
        ev[k] = (BYP && m_cnt == 0 && !flush_i) ? (k < m_enq_cur) : (m_cnt > k);
      end
      chk("mon_occupancy", 64'(occupancy_o), 64'(m_cnt));
      chk("mon_if_ready", 64'(if_ready_o), 64'(m_cnt <= D - FW));
      chk("mon_id_valid", 64'(id_valid_o), 64'(ev));
      if (!flush_i) begin
        for (int k = 0; k < IW; k++) begin
          if (k < int'(id_accept_i) && ev[k]) begin
            checks++;
            if (sb.size() == 0) begin
              failures++;
              $display("FAIL mon_sb_empty lane=%0d actual=entry required=none", k);
            end else begin
              e = sb.pop_front();
              chk("mon_pc", 64'(id_pc_o[32*k +: 32]), 64'(e.pc));
              chk("mon_inst", 64'(id_inst_o[32*k +: 32]), 64'(e.inst));
            end
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    next_pc = 32'h1c00_0000;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    chk("reset_if_ready", 64'(if_ready_o), 64'd1);
    chk("reset_id_valid", 64'(id_valid_o), 64'd0);
    chk("reset_occupancy", 64'(occupancy_o), 64'd0);

    // First two-lane group, nothing accepted
    step(2'b11, 0, 1'b0);
    chk("first_valid", 64'(id_valid_o), 64'd3);
    chk("first_pcs", id_pc_o, 64'h1c00_0004_1c00_0000);
    chk("first_occupancy", 64'(occupancy_o), 64'd2);

    // Fill to full
    step(2'b11, 0, 1'b0);
    step(2'b11, 0, 1'b0);
    chk("ready_at_6", 64'(if_ready_o), 64'd1);
    step(2'b11, 0, 1'b0);
    chk("full_occupancy", 64'(occupancy_o), 64'd8);
    chk("full_not_ready", 64'(if_ready_o), 64'd0);
    step(2'b11, 0, 1'b0);
    chk("full_ignores_fetch", 64'(occupancy_o), 64'd8);
    step(2'b11, 1, 1'b0);
    chk("occ7_occupancy", 64'(occupancy_o), 64'd7);
    chk("occ7_not_ready", 64'(if_ready_o), 64'd0);
    step(2'b11, 0, 1'b0);
    chk("occ7_ignores_fetch", 64'(occupancy_o), 64'd7);

    // Steady enq2/deq2 across many pointer wraps
    repeat (20) step(2'b11, 2, 1'b0);
    chk("steady_occupancy", 64'(occupancy_o), 64'd5);

    // Drain
    repeat (3) step(2'b00, 2, 1'b0);
    chk("drained_occupancy", 64'(occupancy_o), 64'd0);
    chk("drained_sb", 64'(sb.size()), 64'd0);

    // Lane 0 invalid blocks the whole group
    step(2'b10, 0, 1'b0);
    chk("gap_occupancy", 64'(occupancy_o), 64'd0);
    chk("gap_valid", 64'(id_valid_o), 64'd0);

    // Over-accept with one entry
    step(2'b01, 0, 1'b0);
    chk("one_occupancy", 64'(occupancy_o), 64'd1);
    step(2'b00, 2, 1'b0);
    chk("overaccept_occupancy", 64'(occupancy_o), 64'd0);
    chk("overaccept_ready", 64'(if_ready_o), 64'd1);

    // Flush at count 5 with simultaneous enqueue and dequeue
    step(2'b11, 0, 1'b0);
    step(2'b11, 0, 1'b0);
    step(2'b01, 0, 1'b0);
    chk("pre_flush_occupancy", 64'(occupancy_o), 64'd5);
    step(2'b11, 2, 1'b1);
    chk("flush_occupancy", 64'(occupancy_o), 64'd0);
    chk("flush_valid", 64'(id_valid_o), 64'd0);
    chk("flush_ready", 64'(if_ready_o), 64'd1);

    // Empty-queue enqueue latency
    pc0 = next_pc;
    drive(2'b11, 1, 1'b0);
    #1;
`ifdef QUEUE_BYPASS_EN
    chk("bypass_valid", 64'(id_valid_o), 64'd3);
    chk("bypass_pc0", 64'(id_pc_o[31:0]), 64'(pc0));
`else
    chk("no_bypass_valid", 64'(id_valid_o), 64'd0);
`endif
    commit();
`ifdef QUEUE_BYPASS_EN
    chk("bypass_occupancy", 64'(occupancy_o), 64'd1);
`else
    chk("latency_occupancy", 64'(occupancy_o), 64'd2);
`endif

    // Asynchronous reset pulse between clock edges
    step(2'b11, 0, 1'b0);
    #1 rst = 1'b0;
    m_cnt = 0;
    m_nxt = 0;
    sb.delete();
    #1;
    chk("async_rst_occupancy", 64'(occupancy_o), 64'd0);
    chk("async_rst_valid", 64'(id_valid_o), 64'd0);
    chk("async_rst_ready", 64'(if_ready_o), 64'd1);
    #1 rst = 1'b1;
    step(2'b00, 0, 1'b0);
    chk("post_rst_occupancy", 64'(occupancy_o), 64'd0);
    chk("final_sb", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
